// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - SPI mode-0 flash read initiator (cmd 0x03 + 24-bit address)
// Streams the requested byte count out on a valid/ready byte interface.
module spi_flash_reader #(
  parameter int CLK_DIV   = 2,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic                 start,
  input  logic [23:0]          start_addr,
  input  logic [LEN_WIDTH-1:0] length,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           data_o,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 flash_csb,
  output logic                 flash_clk,
  output logic                 flash_io0,
  input  logic                 flash_io1
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, SHIFT_OUT, SHIFT_IN, WAIT_RDY, CS_HOLD, TURN
  } state_t;

  state_t               state;
  logic [DW-1:0]        div_cnt;
  logic [30:0]          tx_sr;
  logic [6:0]           rx_sr;
  logic [5:0]           bit_cnt;
  logic [LEN_WIDTH-1:0] remaining;

  logic tick;
  logic div_run;
  logic can_go;

  assign tick    = (div_cnt == DW'(CLK_DIV - 1));
  assign div_run = (state != IDLE) && (state != WAIT_RDY);
  // A new byte may start clocking only once the previous byte is gone or leaving now.
  assign can_go  = !data_valid || data_ready;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state      <= IDLE;
      div_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      remaining  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_o     <= '0;
      data_valid <= 1'b0;
      flash_csb  <= 1'b1;
      flash_clk  <= 1'b0;
      flash_io0  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;
      if (div_run && !tick) div_cnt <= div_cnt + 1'b1;
      else                  div_cnt <= '0;

      if (abort && busy && state != TURN && state != IDLE) begin
        state      <= TURN;
        div_cnt    <= '0;
        flash_csb  <= 1'b1;
        flash_clk  <= 1'b0;
        flash_io0  <= 1'b0;
        data_valid <= 1'b0;
        done       <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start) begin
            if (length != '0) begin
              // Command MSB goes straight onto io0; the remaining 31 bits wait in tx_sr.
              tx_sr     <= {7'h03, start_addr};
              flash_io0 <= 1'b0;
              remaining <= length;
              bit_cnt   <= '0;
              flash_csb <= 1'b0;
              busy      <= 1'b1;
              state     <= CS_SETUP;
            end else begin
              done <= 1'b1;
            end
          end
          CS_SETUP: if (tick) begin
            flash_clk <= 1'b1;
            state     <= SHIFT_OUT;
          end
          SHIFT_OUT: if (tick) begin
            if (flash_clk) begin
              flash_clk <= 1'b0;
              if (bit_cnt == 6'd31) begin
                flash_io0 <= 1'b0;
                bit_cnt   <= '0;
                state     <= SHIFT_IN;
              end else begin
                flash_io0 <= tx_sr[30];
                tx_sr     <= {tx_sr[29:0], 1'b0};
                bit_cnt   <= bit_cnt + 1'b1;
              end
            end else begin
              flash_clk <= 1'b1;
            end
          end
          SHIFT_IN: if (tick) begin
            if (flash_clk) begin
              flash_clk <= 1'b0;
              if (bit_cnt == 6'd8) begin
                bit_cnt <= '0;
                if (remaining == '0) state <= WAIT_RDY;
              end
            end else if (bit_cnt == '0 && !can_go) begin
              state <= WAIT_RDY;
            end else begin
              flash_clk <= 1'b1;
              rx_sr     <= {rx_sr[5:0], flash_io1};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == 6'd7) begin
                data_o     <= {rx_sr, flash_io1};
                data_valid <= 1'b1;
                remaining  <= remaining - 1'b1;
              end
            end
          end
          // Also used to drain the last byte before releasing chip select.
          WAIT_RDY: if (can_go) begin
            if (remaining == '0) begin
              state <= CS_HOLD;
            end else begin
              flash_clk <= 1'b1;
              rx_sr     <= {rx_sr[5:0], flash_io1};
              bit_cnt   <= 6'd1;
              state     <= SHIFT_IN;
            end
          end
          CS_HOLD: if (tick) begin
            flash_csb <= 1'b1;
            done      <= 1'b1;
            state     <= TURN;
          end
          TURN: if (tick) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb/tb_spi_flash_reader.sv - directed bench for spi_flash_reader with a behavioural SPI flash
// Two instances (CLK_DIV=2 and CLK_DIV=1) share one flash model through a select mux.
module tb_spi_flash_reader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetb, start_a, start_b, abort, data_ready, sel;
  logic [23:0] start_addr;
  logic [15:0] length;
  logic        f_io1 = 1'b0;

  logic       a_busy, a_done, a_dv, a_csb, a_clk, a_io0;
  logic [7:0] a_data;
  logic       b_busy, b_done, b_dv, b_csb, b_clk, b_io0;
  logic [7:0] b_data;

  spi_flash_reader #(.CLK_DIV(2), .LEN_WIDTH(16)) dut_a (
    .clock(clock), .resetb(resetb), .start(start_a), .start_addr(start_addr),
    .length(length), .abort(abort), .busy(a_busy), .done(a_done),
    .data_o(a_data), .data_valid(a_dv), .data_ready(data_ready),
    .flash_csb(a_csb), .flash_clk(a_clk), .flash_io0(a_io0), .flash_io1(f_io1)
  );

  spi_flash_reader #(.CLK_DIV(1), .LEN_WIDTH(16)) dut_b (
    .clock(clock), .resetb(resetb), .start(start_b), .start_addr(start_addr),
    .length(length), .abort(abort), .busy(b_busy), .done(b_done),
    .data_o(b_data), .data_valid(b_dv), .data_ready(data_ready),
    .flash_csb(b_csb), .flash_clk(b_clk), .flash_io0(b_io0), .flash_io1(f_io1)
  );

  logic       m_busy, m_done, m_dv, m_csb, m_sck, m_io0;
  logic [7:0] m_data;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_done = sel ? b_done : a_done;
  assign m_dv   = sel ? b_dv   : a_dv;
  assign m_csb  = sel ? b_csb  : a_csb;
  assign m_sck  = sel ? b_clk  : a_clk;
  assign m_io0  = sel ? b_io0  : a_io0;
  assign m_data = sel ? b_data : a_data;

  // Flash model: command/address in on rising SCK, data out on falling SCK.
  logic [7:0]  mem [0:1023];
  int          rise_cnt = 0;
  logic [31:0] cmd_sh = '0;
  int          idx;
  logic [9:0]  maddr;
  logic [7:0]  cur;

  always @(negedge m_csb) rise_cnt = 0;
  always @(posedge m_sck) if (!m_csb) begin
    if (rise_cnt < 32) cmd_sh = {cmd_sh[30:0], m_io0};
    rise_cnt = rise_cnt + 1;
  end
  always @(negedge m_sck) if (!m_csb && rise_cnt >= 32) begin
    idx   = rise_cnt - 32;
    maddr = 10'(cmd_sh[9:0] + 10'(idx / 8));
    cur   = mem[maddr];
    f_io1 = cur[3'(7 - idx % 8)];
  end

  logic [7:0] got[$];
  int done_cnt, done_csb_bad, edge_viol, csb_low_seen, busy_seen, dv_seen;
  int cyc = 0, last_rise, min_per, max_per;
  logic prev_csb = 1'b1, prev_sck = 1'b0;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (m_dv && data_ready) got.push_back(m_data);
    if (m_done) begin
      done_cnt = done_cnt + 1;
      if (!m_csb) done_csb_bad = done_csb_bad + 1;
    end
    if (!m_csb) csb_low_seen = 1;
    if (m_busy) busy_seen = 1;
    if (m_dv) dv_seen = 1;
    if (m_csb !== prev_csb && (m_sck || prev_sck)) edge_viol = edge_viol + 1;
    if (m_csb) last_rise = -1;
    else if (m_sck && !prev_sck) begin
      if (last_rise >= 0) begin
        if (cyc - last_rise < min_per) min_per = cyc - last_rise;
        if (cyc - last_rise > max_per) max_per = cyc - last_rise;
      end
      last_rise = cyc;
    end
    prev_csb = m_csb;
    prev_sck = m_sck;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_got(input string tag, input int n, input logic [31:0] exp);
    chk({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i),
          (i < got.size()) ? {24'h0, got[i]} : 32'hxxxxxxxx,
          {24'h0, exp[8*(n-1-i) +: 8]});
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_mon();
    got.delete();
    done_cnt = 0; done_csb_bad = 0; edge_viol = 0;
    csb_low_seen = 0; busy_seen = 0; dv_seen = 0;
    last_rise = -1; min_per = 1000; max_per = 0;
  endtask

  task automatic pulse_start(input logic use_b);
    if (use_b) start_b = 1'b1;
    else       start_a = 1'b1;
    tick_n(1);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (m_done !== 1'b1 && n < max) begin
      tick_n(1);
      n++;
    end
    chk({tag, "_done_in_time"}, 32'(n < max), 32'd1);
  endtask

  task automatic wait_rise(input string tag, input int target, input int max);
    int n = 0;
    while (rise_cnt < target && n < max) begin
      tick_n(1);
      n++;
    end
    chk({tag, "_rise_in_time"}, 32'(n < max), 32'd1);
  endtask

  task automatic wait_dv(input string tag, input int max);
    int n = 0;
    while (m_dv !== 1'b1 && n < max) begin
      tick_n(1);
      n++;
    end
    chk({tag, "_dv_in_time"}, 32'(n < max), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
    mem[10'h100] = 8'h12; mem[10'h101] = 8'h34;
    mem[10'h102] = 8'h56; mem[10'h103] = 8'h78;
    mem[10'h000] = 8'hA5; mem[10'h001] = 8'h3C;
    mem[10'h1FF] = 8'h9E;
    resetb = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
    data_ready = 1'b1; sel = 1'b0; start_addr = '0; length = '0;
    clear_mon();
    tick_n(3);
    chk("rst_csb",  32'(a_csb),  32'd1);
    chk("rst_clk",  32'(a_clk),  32'd0);
    chk("rst_io0",  32'(a_io0),  32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_dv",   32'(a_dv),   32'd0);
    chk("rst_data", 32'(a_data), 32'd0);
    resetb = 1'b1;
    tick_n(2);

    // Plain 4-byte read, consumer always ready.
    clear_mon();
    start_addr = 24'h000100; length = 16'd4;
    pulse_start(1'b0);
    wait_done("t1", 2000);
    tick_n(2);
    chk("t1_cmd_addr", cmd_sh, 32'h03000100);
    chk_got("t1", 4, 32'h12345678);
    chk("t1_rises", rise_cnt, 64);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_csb_low_at_done", done_csb_bad, 0);
    chk("t1_sck_high_at_csb_edge", edge_viol, 0);
    tick_n(4);
    chk("t1_idle_busy", 32'(a_busy), 32'd0);

    // Consumer stalls after the first byte.
    clear_mon();
    data_ready = 1'b0;
    pulse_start(1'b0);
    wait_dv("t2", 2000);
    tick_n(50);
    chk("t2_stall_rises", rise_cnt, 40);
    chk("t2_stall_sck", 32'(m_sck), 32'd0);
    chk("t2_stall_csb", 32'(m_csb), 32'd0);
    chk("t2_stall_busy", 32'(m_busy), 32'd1);
    chk("t2_stall_got", got.size(), 0);
    data_ready = 1'b1;
    wait_done("t2", 2000);
    tick_n(2);
    chk_got("t2", 4, 32'h12345678);
    chk("t2_rises", rise_cnt, 64);
    chk("t2_done_cnt", done_cnt, 1);
    tick_n(4);

    // Zero-length request.
    clear_mon();
    length = 16'd0;
    pulse_start(1'b0);
    chk("t3_done_next", 32'(a_done), 32'd1);
    tick_n(5);
    chk("t3_csb_never_low", csb_low_seen, 0);
    chk("t3_busy_never", busy_seen, 0);
    chk("t3_done_cnt", done_cnt, 1);

    // Abort during address phase, start in TURN ignored, then a fresh read.
    clear_mon();
    length = 16'd4; start_addr = 24'h000100;
    pulse_start(1'b0);
    wait_rise("t4", 10, 500);
    abort = 1'b1;
    tick_n(1);
    abort = 1'b0;
    chk("t4_abort_csb",  32'(a_csb),  32'd1);
    chk("t4_abort_clk",  32'(a_clk),  32'd0);
    chk("t4_abort_io0",  32'(a_io0),  32'd0);
    chk("t4_abort_dv",   32'(a_dv),   32'd0);
    chk("t4_abort_done", 32'(a_done), 32'd1);
    chk("t4_abort_busy", 32'(a_busy), 32'd1);
    chk("t4_dv_never", dv_seen, 0);
    clear_mon();
    start_a = 1'b1;
    tick_n(1);
    start_a = 1'b0;
    tick_n(4);
    chk("t4_turn_start_csb", csb_low_seen, 0);
    chk("t4_turn_start_busy", 32'(a_busy), 32'd0);
    length = 16'd2;
    pulse_start(1'b0);
    wait_done("t4", 2000);
    tick_n(2);
    chk_got("t4", 2, 32'h00001234);
    tick_n(4);

    // Asynchronous reset in the middle of byte 2, then a read from address 0.
    clear_mon();
    length = 16'd4;
    pulse_start(1'b0);
    wait_rise("t5", 44, 1000);
    resetb = 1'b0;
    #1;
    chk("t5_rst_csb",  32'(a_csb),  32'd1);
    chk("t5_rst_clk",  32'(a_clk),  32'd0);
    chk("t5_rst_dv",   32'(a_dv),   32'd0);
    chk("t5_rst_busy", 32'(a_busy), 32'd0);
    tick_n(2);
    resetb = 1'b1;
    tick_n(2);
    clear_mon();
    start_addr = 24'h000000; length = 16'd2;
    pulse_start(1'b0);
    wait_done("t5", 2000);
    tick_n(2);
    chk_got("t5", 2, 32'h0000A53C);
    tick_n(4);

    // CLK_DIV=1 instance, single byte.
    sel = 1'b1;
    tick_n(1);
    clear_mon();
    start_addr = 24'h0001FF; length = 16'd1;
    pulse_start(1'b1);
    wait_done("t6", 1000);
    tick_n(2);
    chk("t6_cmd_addr", cmd_sh, 32'h030001FF);
    chk_got("t6", 1, 32'h0000009E);
    chk("t6_rises", rise_cnt, 40);
    chk("t6_min_period", min_per, 2);
    chk("t6_max_period", max_per, 2);
    chk("t6_sck_high_at_csb_edge", edge_viol, 0);
    tick_n(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
